// File: rtl/frog_collision_ctrl.sv
// ---------------------------------------------------------------------------
// frog_collision_ctrl
//
// Purpose:
//   Detects overlap between the frog and a multi-cell car body that can wrap
//   across the right grid edge. Runs the lives / hit / game-over sequencing
//   and tells the frog controller when to respawn. Outputs feed the renderer
//   (freeze, game-over screen) and the 7-segment lives display.
//
// Ports:
//   i_Clk         system clock
//   i_Rst_L       synchronous reset, active low
//   i_Frame_Tick  one-cycle pulse per video frame
//   i_Start       one-cycle restart request (debounced upstream)
//   i_Car_X/Y     car head cell and row
//   i_Frog_X/Y    frog cell and row
//   o_Hit         one-cycle pulse when a collision is accepted
//   o_Frog_Reset  one-cycle pulse, frog returns to its start cell
//   o_Freeze      high in HIT and GAME_OVER, movement blocks stall
//   o_Game_Over   high in GAME_OVER
//   o_Lives       remaining lives
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   PLAY      | normal play, a registered overlap takes a life
//   HIT       | frozen, counting frame ticks before respawn or game over
//   GAME_OVER | frozen with zero lives, waiting for i_Start
// ---------------------------------------------------------------------------
module frog_collision_ctrl #(
    parameter int c_MAX_X        = 20,
    parameter int c_CAR_LEN      = 2,
    parameter int c_INIT_LIVES   = 3,
    parameter int c_HIT_FRAMES   = 30,
    parameter int c_BLANK_CYCLES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic [5:0] i_Car_X,
    input  logic [5:0] i_Car_Y,
    input  logic [5:0] i_Frog_X,
    input  logic [5:0] i_Frog_Y,
    output logic       o_Hit,
    output logic       o_Frog_Reset,
    output logic       o_Freeze,
    output logic       o_Game_Over,
    output logic [2:0] o_Lives
);

    localparam int c_FRAME_W = (c_HIT_FRAMES > 1) ? $clog2(c_HIT_FRAMES) : 1;
    localparam int c_BLANK_W = (c_BLANK_CYCLES > 0) ? $clog2(c_BLANK_CYCLES + 1) : 1;

    localparam logic [6:0]           c_MAX_X7     = 7'(c_MAX_X);
    localparam logic [6:0]           c_CAR_LEN7   = 7'(c_CAR_LEN);
    localparam logic [2:0]           c_LIVES_INIT = 3'(c_INIT_LIVES);
    // Frame timer counts down; the tick that arrives at zero ends the freeze,
    // which is the c_HIT_FRAMES-th tick after entering HIT.
    localparam logic [c_FRAME_W-1:0] c_FRAME_LOAD = c_FRAME_W'(c_HIT_FRAMES - 1);
    localparam logic [c_BLANK_W-1:0] c_BLANK_LOAD = c_BLANK_W'(c_BLANK_CYCLES);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HIT       = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t                 r_State;
    logic                   r_Overlap;
    logic [c_FRAME_W-1:0]   r_Frame_Cnt;
    logic [c_BLANK_W-1:0]   r_Blank_Cnt;

    logic [6:0] w_Car_X;
    logic [6:0] w_Frog_X;
    logic [6:0] w_Dist;
    logic       w_In_Range;
    logic       w_Overlap;

    // Distance from car head to frog, measured toward increasing X with
    // wrap. 7-bit so the wrapped sum cannot overflow even for bad X values.
    always_comb begin
        w_Car_X  = {1'b0, i_Car_X};
        w_Frog_X = {1'b0, i_Frog_X};
        if (w_Frog_X >= w_Car_X) begin
            w_Dist = w_Frog_X - w_Car_X;
        end else begin
            w_Dist = w_Frog_X + c_MAX_X7 - w_Car_X;
        end
        w_In_Range = (w_Car_X < c_MAX_X7) && (w_Frog_X < c_MAX_X7);
        w_Overlap  = (i_Car_Y == i_Frog_Y) && w_In_Range && (w_Dist < c_CAR_LEN7);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State      <= PLAY;
            r_Overlap    <= 1'b0;
            r_Frame_Cnt  <= '0;
            r_Blank_Cnt  <= '0;
            o_Hit        <= 1'b0;
            o_Frog_Reset <= 1'b0;
            o_Freeze     <= 1'b0;
            o_Game_Over  <= 1'b0;
            o_Lives      <= c_LIVES_INIT;
        end else begin
            r_Overlap    <= w_Overlap;
            o_Hit        <= 1'b0;
            o_Frog_Reset <= 1'b0;

            // Blanking hides an overlap that was registered before the frog
            // actually moved back to its start cell.
            if (r_Blank_Cnt != '0) begin
                r_Blank_Cnt <= r_Blank_Cnt - 1'b1;
            end

            case (r_State)
                PLAY: begin
                    if (r_Overlap && (r_Blank_Cnt == '0)) begin
                        r_State     <= HIT;
                        o_Hit       <= 1'b1;
                        o_Freeze    <= 1'b1;
                        r_Frame_Cnt <= c_FRAME_LOAD;
                        if (o_Lives != '0) begin
                            o_Lives <= o_Lives - 1'b1;
                        end
                    end
                end

                HIT: begin
                    if (i_Frame_Tick) begin
                        if (r_Frame_Cnt == '0) begin
                            if (o_Lives == '0) begin
                                r_State     <= GAME_OVER;
                                o_Game_Over <= 1'b1;
                            end else begin
                                r_State      <= PLAY;
                                o_Freeze     <= 1'b0;
                                o_Frog_Reset <= 1'b1;
                                r_Blank_Cnt  <= c_BLANK_LOAD;
                            end
                        end else begin
                            r_Frame_Cnt <= r_Frame_Cnt - 1'b1;
                        end
                    end
                end

                GAME_OVER: begin
                    if (i_Start) begin
                        r_State      <= PLAY;
                        o_Freeze     <= 1'b0;
                        o_Game_Over  <= 1'b0;
                        o_Lives      <= c_LIVES_INIT;
                        o_Frog_Reset <= 1'b1;
                        r_Blank_Cnt  <= c_BLANK_LOAD;
                    end
                end

                default: begin
                    r_State     <= PLAY;
                    o_Freeze    <= 1'b0;
                    o_Game_Over <= 1'b0;
                end
            endcase
        end
    end

endmodule
